// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared MEM->WB bus layout, field offsets, ExcCodes and TLB sequencer states
package wb_stage_pkg;

    localparam int MS_TO_WS_BUS_WD = 124;

    localparam int OFS_TLBP      = 123;
    localparam int OFS_TLBR      = 122;
    localparam int OFS_TLBWI     = 121;
    localparam int OFS_TLBWR     = 120;
    localparam int OFS_DATA_ADDR = 88;
    localparam int OFS_MFC0_RD   = 83;
    localparam int OFS_EX        = 82;
    localparam int OFS_EXCODE    = 77;
    localparam int OFS_BD        = 76;
    localparam int OFS_ERET      = 75;
    localparam int OFS_SEL       = 72;
    localparam int OFS_MTC0      = 71;
    localparam int OFS_MFC0      = 70;
    localparam int OFS_GR_WE     = 69;
    localparam int OFS_DEST      = 64;
    localparam int OFS_RESULT    = 32;
    localparam int OFS_PC        = 0;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_MOD  = 5'h01;
    localparam logic [4:0] EXC_TLBL = 5'h02;
    localparam logic [4:0] EXC_TLBS = 5'h03;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    typedef struct packed {
        logic        tlbp;
        logic        tlbr;
        logic        tlbwi;
        logic        tlbwr;
        logic [31:0] data_addr;
        logic [4:0]  mfc0_rd;
        logic        ex;
        logic [4:0]  excode;
        logic        bd;
        logic        eret;
        logic [2:0]  sel;
        logic        mtc0;
        logic        mfc0;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } ms_ws_bus_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } tlb_state_e;

endpackage

// File: rtl/wb_tlb_seq.sv
// wb_tlb_seq: sequences TLB instructions in WB (request pulse, wait count, commit, refetch)
// Ports:
//   clk, reset  clock, async active-high reset
//   i_valid     WB holds a valid instruction
//   i_ex        that instruction carries an exception
//   i_op        {tlbp, tlbr, tlbwi, tlbwr} of that instruction
//   o_ready_go  instruction may commit this cycle
//   o_req       one-cycle request pulses, same bit order as i_op
//   o_refetch   pulse on commit of tlbr/tlbwi/tlbwr
module wb_tlb_seq
    import wb_stage_pkg::*;
#(
    parameter int TLB_WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_valid,
    input  logic       i_ex,
    input  logic [3:0] i_op,
    output logic       o_ready_go,
    output logic [3:0] o_req,
    output logic       o_refetch
);
    localparam logic [2:0] LOAD = 3'(TLB_WAIT_CYCLES - 1);

    tlb_state_e r_state, w_next;
    logic [2:0] r_cnt, w_cnt_next;
    logic       w_tlb;

    assign w_tlb = i_valid & (|i_op) & !i_ex;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // WAIT lasts r_cnt cycles, so the total stall before DONE is TLB_WAIT_CYCLES
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        o_req      = '0;
        case (r_state)
            S_IDLE: if (w_tlb) begin
                o_req      = i_op;
                w_cnt_next = LOAD;
                w_next     = (LOAD == 3'd0) ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                w_cnt_next = r_cnt - 3'd1;
                w_next     = (r_cnt <= 3'd1) ? S_DONE : S_WAIT;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign o_ready_go = !w_tlb | (r_state == S_DONE);
    assign o_refetch  = w_tlb & (r_state == S_DONE) & (|i_op[2:0]);

endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back stage committing MEM->WB instructions to RF, CP0, trace and flush/TLB control
// Ports:
//   clk, reset                 clock, async active-high reset
//   ms_to_ws_valid/bus/refill  incoming instruction from MEM
//   ws_allowin                 WB can accept a new instruction
//   rf_*, WB_dest, WB_result   register-file write and ID forwarding
//   cp0_*                      mtc0 write, {rd,sel} address, mfc0 read data
//   ws_ex/excode/bd/pc/badvaddr/eret, flush, flush_refill   exception/eret reporting
//   tlb*_req, refetch, refetch_pc                           TLB command pulses and refetch
//   debug_wb_*                 commit trace
module wb_stage #(
    parameter int MS_TO_WS_BUS_WD = 124,
    parameter int TLB_WAIT_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ms_to_ws_valid,
    input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       ms_refill,
    output logic                       ws_allowin,
    output logic                       rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [31:0]                rf_wdata,
    output logic [4:0]                 WB_dest,
    output logic [31:0]                WB_result,
    output logic                       cp0_we,
    output logic [7:0]                 cp0_addr,
    output logic [31:0]                cp0_wdata,
    input  logic [31:0]                cp0_rdata,
    output logic                       ws_ex,
    output logic [4:0]                 ws_excode,
    output logic                       ws_bd,
    output logic [31:0]                ws_pc,
    output logic [31:0]                ws_badvaddr,
    output logic                       ws_eret,
    output logic                       flush,
    output logic                       flush_refill,
    output logic                       tlbp_req,
    output logic                       tlbr_req,
    output logic                       tlbwi_req,
    output logic                       tlbwr_req,
    output logic                       refetch,
    output logic [31:0]                refetch_pc,
    output logic [31:0]                debug_wb_pc,
    output logic [3:0]                 debug_wb_rf_wen,
    output logic [4:0]                 debug_wb_rf_wnum,
    output logic [31:0]                debug_wb_rf_wdata
);
    import wb_stage_pkg::*;

    ms_ws_bus_t r_bus;
    logic       r_valid;
    logic       r_refill;
    logic       w_ready_go;
    logic       w_commit;
    logic [3:0] w_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_bus    <= '0;
            r_refill <= 1'b0;
        end else begin
            if (ws_allowin) r_valid <= ms_to_ws_valid;
            if (ms_to_ws_valid & ws_allowin) begin
                r_bus    <= ms_to_ws_bus;
                r_refill <= ms_refill;
            end
        end
    end

    wb_tlb_seq #(.TLB_WAIT_CYCLES(TLB_WAIT_CYCLES)) u_tlb_seq (
        .clk       (clk),
        .reset     (reset),
        .i_valid   (r_valid),
        .i_ex      (r_bus.ex),
        .i_op      ({r_bus.tlbp, r_bus.tlbr, r_bus.tlbwi, r_bus.tlbwr}),
        .o_ready_go(w_ready_go),
        .o_req     (w_req),
        .o_refetch (refetch)
    );

    assign {tlbp_req, tlbr_req, tlbwi_req, tlbwr_req} = w_req;

    assign w_commit   = r_valid & w_ready_go;
    assign ws_allowin = !r_valid | w_ready_go;

    assign rf_we    = w_commit & r_bus.gr_we & !r_bus.ex;
    assign rf_waddr = r_bus.dest;
    assign rf_wdata = r_bus.mfc0 ? cp0_rdata : r_bus.result;

    // forwarding ignores ready_go so ID sees a stalled producer's dest
    assign WB_dest   = (r_valid & r_bus.gr_we & !r_bus.ex) ? r_bus.dest : 5'd0;
    assign WB_result = rf_wdata;

    assign cp0_we    = w_commit & r_bus.mtc0 & !r_bus.ex;
    assign cp0_addr  = {r_bus.mfc0_rd, r_bus.sel};
    assign cp0_wdata = r_bus.result;

    assign ws_ex        = w_commit & r_bus.ex;
    assign ws_eret      = w_commit & r_bus.eret & !r_bus.ex;
    assign ws_excode    = r_bus.excode;
    assign ws_bd        = r_bus.bd;
    assign ws_pc        = r_bus.pc;
    assign ws_badvaddr  = r_bus.data_addr;
    assign flush        = ws_ex | ws_eret;
    assign flush_refill = ws_ex & r_refill;

    assign refetch_pc = r_valid ? r_bus.pc + 32'd4 : 32'd0;

    assign debug_wb_pc       = r_valid ? r_bus.pc : 32'd0;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage with TLB_WAIT_CYCLES=2
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         ms_to_ws_valid = 1'b0;
    logic [123:0] ms_to_ws_bus = '0;
    logic         ms_refill = 1'b0;
    logic [31:0]  cp0_rdata = '0;
    logic         ws_allowin, rf_we, cp0_we, ws_ex, ws_bd, ws_eret, flush, flush_refill;
    logic         tlbp_req, tlbr_req, tlbwi_req, tlbwr_req, refetch;
    logic [4:0]   rf_waddr, WB_dest, ws_excode, debug_wb_rf_wnum;
    logic [7:0]   cp0_addr;
    logic [3:0]   debug_wb_rf_wen;
    logic [31:0]  rf_wdata, WB_result, cp0_wdata, ws_pc, ws_badvaddr, refetch_pc;
    logic [31:0]  debug_wb_pc, debug_wb_rf_wdata;

    int checks = 0;
    int failures = 0;
    int n_req = 0;
    ms_ws_bus_t b;

    wb_stage #(.MS_TO_WS_BUS_WD(124), .TLB_WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
        .ms_refill(ms_refill), .ws_allowin(ws_allowin), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .WB_dest(WB_dest), .WB_result(WB_result), .cp0_we(cp0_we),
        .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .ws_ex(ws_ex),
        .ws_excode(ws_excode), .ws_bd(ws_bd), .ws_pc(ws_pc), .ws_badvaddr(ws_badvaddr),
        .ws_eret(ws_eret), .flush(flush), .flush_refill(flush_refill), .tlbp_req(tlbp_req),
        .tlbr_req(tlbr_req), .tlbwi_req(tlbwi_req), .tlbwr_req(tlbwr_req), .refetch(refetch),
        .refetch_pc(refetch_pc), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        n_req += int'(tlbp_req) + int'(tlbr_req) + int'(tlbwi_req) + int'(tlbwr_req);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic issue(input ms_ws_bus_t bus, input logic refill);
        ms_to_ws_bus   = bus;
        ms_refill      = refill;
        ms_to_ws_valid = 1'b1;
        @(negedge clk);
        ms_to_ws_valid = 1'b0;
        ms_refill      = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_allowin", 32'(ws_allowin), 32'd1);
        chk("rst_dbg_pc", debug_wb_pc, 32'd0);
        chk("rst_refetch_pc", refetch_pc, 32'd0);
        chk("rst_wb_dest", 32'(WB_dest), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        step();
        reset = 1'b0;
        step();

        b = '0; b.gr_we = 1'b1; b.dest = 5'd5; b.result = 32'h1234; b.pc = 32'hBFC0_0000;
        issue(b, 1'b0);
        chk("alu_rf_we", 32'(rf_we), 32'd1);
        chk("alu_waddr", 32'(rf_waddr), 32'd5);
        chk("alu_wdata", rf_wdata, 32'h1234);
        chk("alu_wen", 32'(debug_wb_rf_wen), 32'hF);
        chk("alu_wb_dest", 32'(WB_dest), 32'd5);
        chk("alu_dbg_pc", debug_wb_pc, 32'hBFC0_0000);
        chk("alu_flush", 32'(flush), 32'd0);
        step();
        chk("bubble_rf_we", 32'(rf_we), 32'd0);
        chk("bubble_wb_dest", 32'(WB_dest), 32'd0);
        chk("bubble_dbg_pc", debug_wb_pc, 32'd0);

        cp0_rdata = 32'h0040_FF01;
        b = '0; b.mfc0 = 1'b1; b.gr_we = 1'b1; b.mfc0_rd = 5'd12; b.dest = 5'd8; b.result = 32'h5555; b.pc = 32'h100;
        issue(b, 1'b0);
        chk("mfc0_addr", 32'(cp0_addr), 32'h60);
        chk("mfc0_wdata", rf_wdata, 32'h0040_FF01);
        chk("mfc0_wb_result", WB_result, 32'h0040_FF01);
        chk("mfc0_rf_we", 32'(rf_we), 32'd1);
        chk("mfc0_cp0_we", 32'(cp0_we), 32'd0);

        b = '0; b.mtc0 = 1'b1; b.mfc0_rd = 5'd12; b.sel = 3'd1; b.result = 32'hDEAD_BEEF; b.pc = 32'h104;
        issue(b, 1'b0);
        chk("mtc0_we", 32'(cp0_we), 32'd1);
        chk("mtc0_wdata", cp0_wdata, 32'hDEAD_BEEF);
        chk("mtc0_addr", 32'(cp0_addr), 32'h61);
        chk("mtc0_rf_we", 32'(rf_we), 32'd0);

        b = '0; b.ex = 1'b1; b.excode = EXC_TLBS; b.gr_we = 1'b1; b.mtc0 = 1'b1; b.tlbwi = 1'b1;
        b.bd = 1'b1; b.dest = 5'd9; b.data_addr = 32'h0040_0004; b.pc = 32'hBFC0_0200;
        issue(b, 1'b1);
        chk("ex_flush", 32'(flush), 32'd1);
        chk("ex_ws_ex", 32'(ws_ex), 32'd1);
        chk("ex_refill", 32'(flush_refill), 32'd1);
        chk("ex_badvaddr", ws_badvaddr, 32'h0040_0004);
        chk("ex_excode", 32'(ws_excode), 32'd3);
        chk("ex_bd", 32'(ws_bd), 32'd1);
        chk("ex_pc", ws_pc, 32'hBFC0_0200);
        chk("ex_rf_we", 32'(rf_we), 32'd0);
        chk("ex_cp0_we", 32'(cp0_we), 32'd0);
        chk("ex_wb_dest", 32'(WB_dest), 32'd0);
        chk("ex_tlbwi_req", 32'(tlbwi_req), 32'd0);
        chk("ex_allowin", 32'(ws_allowin), 32'd1);
        chk("ex_eret", 32'(ws_eret), 32'd0);
        step();
        chk("ex_flush_once", 32'(flush), 32'd0);

        b = '0; b.eret = 1'b1; b.pc = 32'h300;
        issue(b, 1'b1);
        chk("eret_ws_eret", 32'(ws_eret), 32'd1);
        chk("eret_flush", 32'(flush), 32'd1);
        chk("eret_refill", 32'(flush_refill), 32'd0);
        chk("eret_ws_ex", 32'(ws_ex), 32'd0);

        b = '0; b.tlbwi = 1'b1; b.pc = 32'hBFC0_0100;
        issue(b, 1'b0);
        chk("tlbwi_c1_req", 32'(tlbwi_req), 32'd1);
        chk("tlbwi_c1_allowin", 32'(ws_allowin), 32'd0);
        chk("tlbwi_c1_refetch", 32'(refetch), 32'd0);
        step();
        chk("tlbwi_c2_req", 32'(tlbwi_req), 32'd0);
        chk("tlbwi_c2_allowin", 32'(ws_allowin), 32'd0);
        step();
        chk("tlbwi_c3_allowin", 32'(ws_allowin), 32'd1);
        chk("tlbwi_c3_refetch", 32'(refetch), 32'd1);
        chk("tlbwi_c3_refetch_pc", refetch_pc, 32'hBFC0_0104);
        chk("tlbwi_c3_req", 32'(tlbwi_req), 32'd0);
        chk("tlbwi_c3_dbg_pc", debug_wb_pc, 32'hBFC0_0100);
        step();
        chk("tlbwi_after_refetch", 32'(refetch), 32'd0);

        b = '0; b.tlbp = 1'b1; b.pc = 32'hBFC0_0200;
        issue(b, 1'b0);
        chk("tlbp_c1_req", 32'(tlbp_req), 32'd1);
        chk("tlbp_c1_allowin", 32'(ws_allowin), 32'd0);
        step();
        chk("tlbp_c2_req", 32'(tlbp_req), 32'd0);
        chk("tlbp_c2_allowin", 32'(ws_allowin), 32'd0);
        step();
        chk("tlbp_c3_allowin", 32'(ws_allowin), 32'd1);
        chk("tlbp_c3_refetch", 32'(refetch), 32'd0);
        step();

        b = '0; b.tlbr = 1'b1; b.pc = 32'h0000_1000;
        issue(b, 1'b0);
        chk("tlbr_c1_req", 32'(tlbr_req), 32'd1);
        b = '0; b.gr_we = 1'b1; b.dest = 5'd7; b.result = 32'hA5A5; b.pc = 32'h0000_1004;
        ms_to_ws_bus = b;
        ms_to_ws_valid = 1'b1;
        step();
        chk("tlbr_c2_allowin", 32'(ws_allowin), 32'd0);
        chk("tlbr_c2_req", 32'(tlbr_req), 32'd0);
        chk("tlbr_c2_rf_we", 32'(rf_we), 32'd0);
        step();
        chk("tlbr_c3_refetch", 32'(refetch), 32'd1);
        chk("tlbr_c3_refetch_pc", refetch_pc, 32'h0000_1004);
        chk("tlbr_c3_dbg_pc", debug_wb_pc, 32'h0000_1000);
        step();
        ms_to_ws_valid = 1'b0;
        chk("b2b_rf_we", 32'(rf_we), 32'd1);
        chk("b2b_waddr", 32'(rf_waddr), 32'd7);
        chk("b2b_wdata", rf_wdata, 32'hA5A5);
        chk("b2b_dbg_pc", debug_wb_pc, 32'h0000_1004);
        chk("b2b_req", 32'(tlbr_req), 32'd0);
        chk("b2b_refetch", 32'(refetch), 32'd0);
        step();
        chk("b2b_once", 32'(rf_we), 32'd0);

        b = '0; b.tlbwr = 1'b1; b.pc = 32'hFFFF_FFFC;
        issue(b, 1'b0);
        chk("tlbwr_req", 32'(tlbwr_req), 32'd1);
        step();
        step();
        chk("tlbwr_refetch", 32'(refetch), 32'd1);
        chk("tlbwr_wrap_pc", refetch_pc, 32'd0);
        step();

        b = '0; b.tlbwr = 1'b1; b.pc = 32'h0000_2000;
        issue(b, 1'b0);
        chk("rstw_c1_req", 32'(tlbwr_req), 32'd1);
        step();
        reset = 1'b1;
        #1;
        chk("rstw_req", 32'(tlbwr_req), 32'd0);
        chk("rstw_refetch", 32'(refetch), 32'd0);
        chk("rstw_allowin", 32'(ws_allowin), 32'd1);
        chk("rstw_dbg_pc", debug_wb_pc, 32'd0);
        chk("rstw_refetch_pc", refetch_pc, 32'd0);
        chk("rstw_ws_pc", ws_pc, 32'd0);
        step();
        reset = 1'b0;
        step();
        step();
        chk("rstw_no_pulse", 32'(tlbwr_req), 32'd0);
        chk("req_total", 32'(n_req), 32'd5);

        b = '0; b.gr_we = 1'b1; b.dest = 5'd3; b.result = 32'h0BAD_F00D; b.pc = 32'h0000_3000;
        issue(b, 1'b0);
        chk("post_rst_rf_we", 32'(rf_we), 32'd1);
        chk("post_rst_waddr", 32'(debug_wb_rf_wnum), 32'd3);
        chk("post_rst_wdata", debug_wb_rf_wdata, 32'h0BAD_F00D);
        chk("post_rst_dbg_pc", debug_wb_pc, 32'h0000_3000);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
